mult: RTL and testbench
=======================

# mult

Sequential signed 32×32 multiplier that produces a 64-bit product split into `high`/`low`. It is the multiply counterpart of the iterative divider and sits in the same multiply/divide unit beside it. It uses the same start-pulse/end-flag convention, so the control unit drives both blocks the same way. The datapath is radix-2 Booth, one iteration per clock, 32 iterations.

## Interface
- No parameters; widths are fixed at 32-bit operands and a 64-bit product.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset. 0 clears all state immediately.
- `mult`, input, 1: start. Sampled on the rising edge. 1 loads `a`/`b` and begins an operation.
- `a`, input, 32: multiplicand, two's complement. Sampled only at the start edge.
- `b`, input, 32: multiplier, two's complement. Sampled only at the start edge.
- `high`, output, 32: product bits [63:32]. Registered.
- `low`, output, 32: product bits [31:0]. Registered.
- `mult_end`, output, 1: one-cycle completion pulse. Registered.
- `busy`, output, 1: high while iterations are pending. Registered.

## Operation
- Internal state:
  - `acc`: 33-bit accumulator, sign-extended, so that subtracting M = −2^31 cannot overflow.
  - `q`: 32 bits, holds the multiplier.
  - `q_m1`: 1 bit.
  - `m`: 33-bit sign-extended multiplicand.
  - `cnt`: 6-bit iteration counter.
- States: IDLE, RUN.
- IDLE:
  - On `mult`=1: `acc`←0, `q`←`b`, `q_m1`←0, `m`←{a[31],a}, `cnt`←32, `busy`←1, go to RUN.
  - Otherwise hold.
- RUN, one Booth step per edge:
  - {q[0],q_m1} = 01: `acc`+`m`.
  - {q[0],q_m1} = 10: `acc`−`m`.
  - 00 or 11: no add/subtract.
  - Then arithmetic-shift {acc,q,q_m1} right by 1, replicating acc[32].
  - `cnt` decrements by 1.
- RUN, final step (the one taking `cnt` to 0), in the same edge:
  - `high`←acc[31:0] and `low`←q, both taken after the shift.
  - `mult_end`←1, `busy`←0, go to IDLE.
- Arithmetic: the result is the exact signed 64-bit product for all operand pairs, including 0x80000000×0x80000000. No overflow or flag outputs.
- `high`/`low` hold their last result until the next completion. They never show intermediate values.
- `mult`=1 in RUN aborts the current operation and restarts with the new `a`/`b`. `cnt` reloads to 32. The aborted operation produces no `mult_end`.
- `mult` held high for several cycles restarts on every sampled edge. Completion happens 32 edges after the last edge with `mult`=1.

## Timing
- Reset (`reset`=0, asynchronous): `high`=0, `low`=0, `mult_end`=0, `busy`=0, state IDLE, all internal registers 0.
  - Takes effect without a clock edge.
  - Reset mid-operation discards the operation; no `mult_end` follows.
  - On `reset` release, the block is in IDLE and accepts `mult` on the next edge.
- Latency: start at edge E0. Iterations occur on E1..E32.
  - `high`/`low` update and `mult_end` rises on E32.
  - `mult_end` falls on E33 unless another operation also completes there, which is impossible.
  - 32 cycles from start to result.
- `busy` is 1 from E0 to E32 and 0 after E32.
- Back-to-back: `mult`=1 on E32, the completion edge, is accepted. It starts a new operation on the same edge that `mult_end` rises; the new operation completes on E64.
- `mult_end` is never asserted for more than one cycle and never asserted in IDLE without a completion.

## Test plan
- Positive operands: reset, `a`=3, `b`=5, pulse `mult` → on E32 `high`=0x00000000, `low`=0x0000000F, `mult_end`=1 for exactly one cycle, `busy` low afterwards.
- Mixed and negative signs:
  - −7×6 → `high`=0xFFFFFFFF, `low`=0xFFFFFFD6.
  - 0xFFFFFFFF×0xFFFFFFFF → `high`=0, `low`=1.
  - 0x7FFFFFFF×0xFFFFFFFF → `high`=0xFFFFFFFF, `low`=0x80000001.
- Extreme operands: 0x80000000×0x80000000 → `high`=0x40000000, `low`=0. Also 0×0x12345678 → `high`=`low`=0.
- Restart mid-operation: start 3×5, then at E10 start 4×4 → no `mult_end` at the original E32; `mult_end` 32 edges after the second start with `low`=0x10. `high`/`low` unchanged before that.
- Async reset mid-operation:
  - Start 100×100, drive `reset`=0 between edges at cycle 12 → outputs go to 0 immediately, without a clock edge; no `mult_end`.
  - After release, 2×3 → `low`=6 at E32.
- Hold and back-to-back: after 9×9 completes (`low`=81), leave `mult`=0 for 50 cycles → `low` stays 81, `mult_end` stays 0. Then `mult`=1 on the completion edge of an operation → the next result appears exactly 32 edges later.

Source files
------------

// File: rtl/mult_if.sv
// mult_if: handshake and data bundle for the sequential signed multiplier.
//   mult     : start pulse, sampled on the rising clock edge
//   a, b     : 32-bit two's-complement multiplicand / multiplier
//   high     : product bits [63:32]
//   low      : product bits [31:0]
//   mult_end : one-cycle completion pulse
//   busy     : high while Booth iterations are pending
// The master modport is the requester (control unit or testbench) and
// the slave modport is the multiplier.
interface mult_if;
    logic        mult;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] high;
    logic [31:0] low;
    logic        mult_end;
    logic        busy;

    modport master (
        output mult, a, b,
        input  high, low, mult_end, busy
    );

    modport slave (
        input  mult, a, b,
        output high, low, mult_end, busy
    );
endinterface

// File: rtl/mult.sv
// mult: sequential signed 32x32 multiplier, radix-2 Booth, one iteration
// per clock and 32 iterations per product.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous active-low reset, clears every register
//   bus   : mult_if slave (mult, a, b in; high, low, mult_end, busy out)
// A start edge loads the operands. The 32nd following edge writes the
// product to high/low and pulses mult_end. A start during RUN abandons
// the running product and begins again. A start on the completion edge
// itself both completes the old product and begins the new one.
module mult (
    input  logic clk,
    input  logic reset,
    mult_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_r, state_s;
    // acc and m are 33 bits so that subtracting m = -2^31 cannot overflow.
    logic [32:0] acc_r, acc_s;
    logic [32:0] m_r, m_s;
    logic [31:0] q_r, q_s;
    logic        q_m1_r, q_m1_s;
    logic [5:0]  cnt_r, cnt_s;
    logic [31:0] high_r, high_s;
    logic [31:0] low_r, low_s;
    logic        end_r, end_s;
    logic        busy_r, busy_s;
    logic        start_s;

    logic [32:0] sum_s;
    logic [32:0] step_acc_s;
    logic [31:0] step_q_s;
    logic        step_q_m1_s;

    // One Booth step: add, subtract or skip m, then shift {acc,q,q_m1} right arithmetically.
    always_comb begin
        sum_s = acc_r;
        case ({q_r[0], q_m1_r})
            2'b01:   sum_s = acc_r + m_r;
            2'b10:   sum_s = acc_r - m_r;
            default: sum_s = acc_r;
        endcase
        step_acc_s  = {sum_s[32], sum_s[32:1]};
        step_q_s    = {sum_s[0], q_r[31:1]};
        step_q_m1_s = q_r[0];
    end

    // Next-state and datapath control for the IDLE/RUN sequencer.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        m_s     = m_r;
        q_s     = q_r;
        q_m1_s  = q_m1_r;
        cnt_s   = cnt_r;
        high_s  = high_r;
        low_s   = low_r;
        end_s   = 1'b0;
        busy_s  = busy_r;
        start_s = 1'b0;

        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
                if (bus.mult) begin
                    start_s = 1'b1;
                end else begin
                    start_s = 1'b0;
                end
            end
            RUN: begin
                acc_s   = step_acc_s;
                q_s     = step_q_s;
                q_m1_s  = step_q_m1_s;
                cnt_s   = cnt_r - 6'd1;
                start_s = bus.mult;
                if (cnt_r == 6'd1) begin
                    // Final step: publish the shifted result in this same edge.
                    high_s  = step_acc_s[31:0];
                    low_s   = step_q_s;
                    end_s   = 1'b1;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    busy_s  = 1'b1;
                    state_s = RUN;
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase

        // A start overrides the step (restart) but not a completion on the same edge.
        if (start_s) begin
            acc_s   = 33'd0;
            q_s     = bus.b;
            q_m1_s  = 1'b0;
            m_s     = {bus.a[31], bus.a};
            cnt_s   = 6'd32;
            busy_s  = 1'b1;
            state_s = RUN;
        end else begin
            // keep the step/hold values chosen above
        end
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            acc_r   <= 33'd0;
            m_r     <= 33'd0;
            q_r     <= 32'd0;
            q_m1_r  <= 1'b0;
            cnt_r   <= 6'd0;
            high_r  <= 32'd0;
            low_r   <= 32'd0;
            end_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            m_r     <= m_s;
            q_r     <= q_s;
            q_m1_r  <= q_m1_s;
            cnt_r   <= cnt_s;
            high_r  <= high_s;
            low_r   <= low_s;
            end_r   <= end_s;
            busy_r  <= busy_s;
        end
    end

    assign bus.high     = high_r;
    assign bus.low      = low_r;
    assign bus.mult_end = end_r;
    assign bus.busy     = busy_r;

endmodule

// File: tb/tb_mult.sv
// tb_mult: table-driven directed test of the sequential Booth multiplier,
// plus hand-written sequences for restart, asynchronous reset, hold and
// back-to-back operation. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_mult;

    logic clk;
    logic reset;
    mult_if bus_if ();

    mult dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [0:10];

    int checks = 0;
    int errors = 0;
    logic [31:0] last_hi = 32'd0;
    logic [31:0] last_lo = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Caller is at a falling edge; returns at the falling edge after the start edge E0.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        bus_if.mult = 1'b1;
        bus_if.a    = a;
        bus_if.b    = b;
        @(posedge clk);
        @(negedge clk);
        bus_if.mult = 1'b0;
    endtask

    // Counts edges until mult_end is seen (0 if never within 40), and
    // reports whether high/low kept the previous result until then.
    task automatic wait_end(output int n, output bit held_ok);
        bit done;
        n       = 0;
        held_ok = 1'b1;
        done    = 1'b0;
        for (int i = 1; i <= 40 && !done; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_if.mult_end) begin
                n    = i;
                done = 1'b1;
            end else if (bus_if.high !== last_hi || bus_if.low !== last_lo) begin
                held_ok = 1'b0;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo);
        int n;
        bit ok;
        start_op(a, b);
        chk({name, "_busy"}, {63'd0, bus_if.busy}, 64'd1);
        wait_end(n, ok);
        chk({name, "_latency"}, 64'(n), 64'd32);
        chk({name, "_held"}, {63'd0, ok}, 64'd1);
        chk({name, "_result"}, {bus_if.high, bus_if.low}, {hi, lo});
        last_hi = hi;
        last_lo = lo;
        @(posedge clk);
        @(negedge clk);
        chk({name, "_end_drop"}, {63'd0, bus_if.mult_end}, 64'd0);
        chk({name, "_idle"}, {63'd0, bus_if.busy}, 64'd0);
    endtask

    initial begin
        int n;
        bit ok;
        bit seen;

        vecs[0]  = '{32'd3,         32'd5,         32'h00000000, 32'h0000000F};
        vecs[1]  = '{32'hFFFFFFF9,  32'd6,         32'hFFFFFFFF, 32'hFFFFFFD6};
        vecs[2]  = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000, 32'h00000001};
        vecs[3]  = '{32'h7FFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF, 32'h80000001};
        vecs[4]  = '{32'h80000000,  32'h80000000,  32'h40000000, 32'h00000000};
        vecs[5]  = '{32'h00000000,  32'h12345678,  32'h00000000, 32'h00000000};
        vecs[6]  = '{32'hFFFFFFFD,  32'hFFFFFFFB,  32'h00000000, 32'h0000000F};
        vecs[7]  = '{32'hFFFFFFFF,  32'h80000000,  32'h00000000, 32'h80000000};
        vecs[8]  = '{32'h7FFFFFFF,  32'h7FFFFFFF,  32'h3FFFFFFF, 32'h00000001};
        vecs[9]  = '{32'h00010000,  32'h00010000,  32'h00000001, 32'h00000000};
        vecs[10] = '{32'd9,         32'd9,         32'h00000000, 32'h00000051};

        reset       = 1'b0;
        bus_if.mult = 1'b0;
        bus_if.a    = 32'd0;
        bus_if.b    = 32'd0;
        #1;
        chk("reset_outputs", {bus_if.high, bus_if.low}, 64'd0);
        chk("reset_flags", {62'd0, bus_if.mult_end, bus_if.busy}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i <= 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
        end

        // Hold: 9x9 = 81 is the last result; idle for 50 cycles.
        seen = 1'b0;
        ok   = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_if.mult_end) seen = 1'b1;
            if (bus_if.low !== 32'd81 || bus_if.high !== 32'd0) ok = 1'b0;
        end
        chk("hold_no_end", {63'd0, seen}, 64'd0);
        chk("hold_value", {63'd0, ok}, 64'd1);

        // Restart at E10: 3x5 is abandoned, 4x4 completes 32 edges later.
        start_op(32'd3, 32'd5);
        seen = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_if.mult_end) seen = 1'b1;
        end
        start_op(32'd4, 32'd4);
        wait_end(n, ok);
        chk("restart_early_end", {63'd0, seen}, 64'd0);
        chk("restart_latency", 64'(n), 64'd32);
        chk("restart_held", {63'd0, ok}, 64'd1);
        chk("restart_result", {bus_if.high, bus_if.low}, 64'h0000000000000010);
        last_hi = 32'd0;
        last_lo = 32'h10;

        // Asynchronous reset between edges in the middle of 100x100.
        start_op(32'd100, 32'd100);
        for (int i = 1; i <= 11; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2 reset = 1'b0;
        #1;
        chk("async_reset_result", {bus_if.high, bus_if.low}, 64'd0);
        chk("async_reset_flags", {62'd0, bus_if.mult_end, bus_if.busy}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_if.mult_end || bus_if.busy) seen = 1'b1;
        end
        chk("async_reset_no_end", {63'd0, seen}, 64'd0);
        last_hi = 32'd0;
        last_lo = 32'd0;
        run_op("after_reset", 32'd2, 32'd3, 32'd0, 32'd6);

        // Back-to-back: 6x7 started on the edge where 5x7 completes.
        start_op(32'd5, 32'd7);
        seen = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_if.mult_end) seen = 1'b1;
        end
        chk("b2b_early_end", {63'd0, seen}, 64'd0);
        bus_if.mult = 1'b1;
        bus_if.a    = 32'd6;
        bus_if.b    = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus_if.mult = 1'b0;
        chk("b2b_first_end", {63'd0, bus_if.mult_end}, 64'd1);
        chk("b2b_first_result", {bus_if.high, bus_if.low}, 64'd35);
        chk("b2b_still_busy", {63'd0, bus_if.busy}, 64'd1);
        last_hi = 32'd0;
        last_lo = 32'd35;
        wait_end(n, ok);
        chk("b2b_latency", 64'(n), 64'd32);
        chk("b2b_held", {63'd0, ok}, 64'd1);
        chk("b2b_second_result", {bus_if.high, bus_if.low}, 64'd42);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_end_drop", {63'd0, bus_if.mult_end}, 64'd0);
        chk("b2b_idle", {63'd0, bus_if.busy}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
